// File: rtl/sim_chk_pkg.sv
// Shared types and constants for the end-of-program self-checker.
//   chk_state_e      : checker FSM states
//   HALT_INST_DEF    : default halt opcode (ebreak)
//   ANSWER_START_DEF : default DM byte address of answer word 0
//   clog2()          : ceiling log2, minimum result 1
package sim_chk_pkg;

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_DRAIN = 3'd1,
      ST_REG   = 3'd2,
      ST_MEM   = 3'd3,
      ST_DONE  = 3'd4
   } chk_state_e;

   localparam logic [31:0] HALT_INST_DEF    = 32'h0010_0073;
   localparam logic [15:0] ANSWER_START_DEF = 16'h9000;

   // Ceiling log2 used for derived index/counter widths; never returns 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/sim_end_checker_if.sv
// Read-port bundle between the checker and the register file, data memory
// and golden store. Every source answers with a 1-cycle read latency.
//   master : checker side (drives addresses, receives data)
//   slave  : storage side (receives addresses, drives data)
interface sim_end_checker_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IDX_W  = 11
);
   logic [4:0]        reg_rd_addr;
   logic [XLEN-1:0]   reg_rd_data;
   logic [ADDR_W-1:0] dm_rd_addr;
   logic [XLEN-1:0]   dm_rd_data;
   logic [IDX_W-1:0]  gold_rd_addr;
   logic [XLEN-1:0]   gold_rd_data;

   modport master (
      output reg_rd_addr, dm_rd_addr, gold_rd_addr,
      input  reg_rd_data, dm_rd_data, gold_rd_data
   );

   modport slave (
      input  reg_rd_addr, dm_rd_addr, gold_rd_addr,
      output reg_rd_data, dm_rd_data, gold_rd_data
   );
endinterface

// File: rtl/sim_end_checker_watchdog.sv
// cycle_watchdog: free-running cycle counter with enable and clear.
//   clk, rst_n : clock, async active-low reset
//   en_i       : count this cycle
//   clr_i      : restart from 0 (wins over en_i)
//   expire_c   : count reaches MAX_CYCLES-1 on this edge (combinational)
module cycle_watchdog
   import sim_chk_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_c
);

   localparam int unsigned CNT_W = clog2(MAX_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CNT_W'(1);
   end

   // Flag the edge on which the count steps onto its limit value.
   assign expire_c = en_i && !clr_i && (cnt_q == CNT_W'(MAX_CYCLES - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sim_end_checker.sv
// End-of-program self-checker: waits for the halt opcode at IF, drains the
// pipeline, scans the register file then the DM answer region against a
// golden store, and reports pass/fail, error count and mismatch detail.
// A cycle watchdog ends the run with chk_timeout if halt never arrives.
//   clk, rst_n     : clock, async active-low reset
//   inst_if        : IF-stage instruction
//   mem_words_cfg  : DM words to check, latched when halt is seen
//   rd             : read ports to regfile / DM / golden store (master)
//   chk_busy/done/pass/timeout, err_cnt : run status
//   mm_valid/idx/got/exp                : per-mismatch detail
// Optional build macro: CHK_STOP_ON_ERR_EN stops the scan at the first
// mismatch; without it the full scan runs and counts every error.
module sim_end_checker
   import sim_chk_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned NUM_REGS      = 32,
   parameter int unsigned MAX_MEM_WORDS = 1024,
   parameter int unsigned ADDR_W        = 16,
   parameter logic [ADDR_W-1:0] ANSWER_START = ADDR_W'(ANSWER_START_DEF),
   parameter logic [XLEN-1:0]   HALT_INST    = XLEN'(HALT_INST_DEF),
   parameter int unsigned DRAIN_CYCLES  = 8,
   parameter int unsigned MAX_CYCLES    = 1000000,
   parameter int unsigned ERR_W         = 16,
   parameter int unsigned IDX_W         = clog2(NUM_REGS + MAX_MEM_WORDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [XLEN-1:0]     inst_if,
   input  logic [IDX_W-1:0]    mem_words_cfg,
   sim_end_checker_if.master   rd,
   output logic                chk_busy,
   output logic                chk_done,
   output logic                chk_pass,
   output logic                chk_timeout,
   output logic [ERR_W-1:0]    err_cnt,
   output logic                mm_valid,
   output logic [IDX_W-1:0]    mm_idx,
   output logic [XLEN-1:0]     mm_got,
   output logic [XLEN-1:0]     mm_exp
);

   localparam int unsigned DRN_W = 8;

   chk_state_e        state_q, state_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic [IDX_W-1:0]  mem_left_q, mem_left_d;
   logic [4:0]        reg_addr_q, reg_addr_d;
   logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
   logic [IDX_W-1:0]  gold_addr_q, gold_addr_d;
   logic              iss_vld_q, iss_vld_d;
   logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;
   logic              iss_mem_q, iss_mem_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              mm_vld_q, mm_vld_d;
   logic [IDX_W-1:0]  mm_idx_q, mm_idx_d;
   logic [XLEN-1:0]   mm_got_q, mm_got_d;
   logic [XLEN-1:0]   mm_exp_q, mm_exp_d;

   logic              wd_expire_c;
   logic [XLEN-1:0]   cmp_got_c;

   // Watchdog runs only while the program is running.
   cycle_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_wd (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (state_q == ST_RUN),
      .clr_i    (state_q == ST_DONE),
      .expire_c (wd_expire_c)
   );

   // Read data of the word issued last cycle.
   assign cmp_got_c = iss_mem_q ? rd.dm_rd_data : rd.reg_rd_data;

   // Next-state, issue and compare logic.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      mem_left_d  = mem_left_q;
      reg_addr_d  = reg_addr_q;
      dm_addr_d   = dm_addr_q;
      gold_addr_d = gold_addr_q;
      iss_vld_d   = 1'b0;
      iss_idx_d   = iss_idx_q;
      iss_mem_d   = iss_mem_q;
      timeout_d   = timeout_q;
      err_d       = err_q;
      mm_vld_d    = 1'b0;
      mm_idx_d    = mm_idx_q;
      mm_got_d    = mm_got_q;
      mm_exp_d    = mm_exp_q;

      unique case (state_q)
         ST_RUN: begin
            // Halt takes priority over a same-cycle watchdog expiry.
            if (inst_if == HALT_INST) begin
               state_d    = ST_DRAIN;
               drain_d    = DRN_W'(DRAIN_CYCLES);
               mem_left_d = mem_words_cfg;
            end else if (wd_expire_c) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - DRN_W'(1);
            if (drain_q == DRN_W'(1)) begin
               state_d     = ST_REG;
               reg_addr_d  = '0;
               gold_addr_d = '0;
            end
         end
         ST_REG: begin
            // Address registers hold the index being issued this cycle.
            iss_vld_d   = 1'b1;
            iss_idx_d   = gold_addr_q;
            iss_mem_d   = 1'b0;
            gold_addr_d = gold_addr_q + IDX_W'(1);
            if (gold_addr_q == IDX_W'(NUM_REGS - 1)) begin
               if (mem_left_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_MEM;
                  dm_addr_d = ANSWER_START;
               end
            end else begin
               reg_addr_d = 5'(gold_addr_q + IDX_W'(1));
            end
         end
         ST_MEM: begin
            iss_vld_d  = 1'b1;
            iss_idx_d  = gold_addr_q;
            iss_mem_d  = 1'b1;
            mem_left_d = mem_left_q - IDX_W'(1);
            if (mem_left_q == IDX_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               gold_addr_d = gold_addr_q + IDX_W'(1);
               dm_addr_d   = dm_addr_q + ADDR_W'(4);
            end
         end
         ST_DONE: begin
         end
         default: state_d = ST_RUN;
      endcase

      // Compare stage: one cycle behind issue.
      if (iss_vld_q && (cmp_got_c !== rd.gold_rd_data)) begin
         mm_vld_d = 1'b1;
         mm_idx_d = iss_idx_q;
         mm_got_d = cmp_got_c;
         mm_exp_d = rd.gold_rd_data;
         if (err_q != '1) err_d = err_q + ERR_W'(1);
`ifdef CHK_STOP_ON_ERR_EN
         // Stop at the first failure and drop anything still in flight.
         state_d   = ST_DONE;
         iss_vld_d = 1'b0;
`endif
      end
   end

   // Status: done only once the last in-flight compare has been counted.
   always_comb begin
      busy_d = (state_d == ST_DRAIN) || (state_d == ST_REG) || (state_d == ST_MEM);
      done_d = (state_d == ST_DONE) && !iss_vld_d;
      pass_d = done_d && (err_d == '0) && !timeout_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         drain_q     <= '0;
         mem_left_q  <= '0;
         reg_addr_q  <= '0;
         dm_addr_q   <= '0;
         gold_addr_q <= '0;
         iss_vld_q   <= 1'b0;
         iss_idx_q   <= '0;
         iss_mem_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_q       <= '0;
         mm_vld_q    <= 1'b0;
         mm_idx_q    <= '0;
         mm_got_q    <= '0;
         mm_exp_q    <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         mem_left_q  <= mem_left_d;
         reg_addr_q  <= reg_addr_d;
         dm_addr_q   <= dm_addr_d;
         gold_addr_q <= gold_addr_d;
         iss_vld_q   <= iss_vld_d;
         iss_idx_q   <= iss_idx_d;
         iss_mem_q   <= iss_mem_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
         mm_vld_q    <= mm_vld_d;
         mm_idx_q    <= mm_idx_d;
         mm_got_q    <= mm_got_d;
         mm_exp_q    <= mm_exp_d;
      end
   end

   assign rd.reg_rd_addr  = reg_addr_q;
   assign rd.dm_rd_addr   = dm_addr_q;
   assign rd.gold_rd_addr = gold_addr_q;
   assign chk_busy        = busy_q;
   assign chk_done        = done_q;
   assign chk_pass        = pass_q;
   assign chk_timeout     = timeout_q;
   assign err_cnt         = err_q;
   assign mm_valid        = mm_vld_q;
   assign mm_idx          = mm_idx_q;
   assign mm_got          = mm_got_q;
   assign mm_exp          = mm_exp_q;

endmodule
